// File: rtl/rng_pkg.sv
// Shared types and helpers for the ranged random source.
// LFSR tap table, draw FSM state and counter sizing.
package rng_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_e;

  localparam int TRIES_W_DEF = $clog2(8);

  // Maximal-length Fibonacci masks, MSB-first tap numbering.
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    case (width)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rng_range_lfsr_core.sv
// Fibonacci LFSR with seed load taking priority over step.
// A zero seed is replaced by SEED so the lock-up state never appears.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [15:0]      TAPS16 = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? SEED : seed_i;
    end else if (step_i) begin
      state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/rng_range.sv
// LFSR random source with a request/valid draw engine returning
// a value in 0..max_i by bounded rejection sampling.
module rng_range
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               OUT_W     = 4,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             req_i,
  input  logic [OUT_W-1:0] max_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [OUT_W-1:0] value_o,
  output logic             fb_o
);

  localparam int TRIES_W = cnt_w(MAX_TRIES);
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   max_q, max_d;
  logic [TRIES_W-1:0] tries_q, tries_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               fb_q, fb_d;

  logic [WIDTH-1:0]   lfsr;
  logic [OUT_W-1:0]   cand;
  logic               step;

  assign cand = lfsr[OUT_W-1:0];

  // Accept edge never steps; a seed load freezes the draw for one edge.
  assign step = !seed_load_i &&
                ((state_q == DRAW) || (en_i && !req_i));

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .step_i  (step),
    .load_i  (seed_load_i),
    .seed_i  (seed_i),
    .state_o (lfsr)
  );

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    tries_d = tries_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    value_d = value_q;
    fb_d    = fb_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = DRAW;
          max_d   = max_i;
          tries_d = '0;
          busy_d  = 1'b1;
        end
      end
      DRAW: begin
        if (!seed_load_i) begin
          if (cand <= max_q) begin
            value_d = cand;
            fb_d    = 1'b0;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else if (tries_q == LAST_TRY) begin
            value_d = '0;
            fb_d    = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      max_q   <= '0;
      tries_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      tries_q <= tries_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      value_q <= value_d;
      fb_q    <= fb_d;
    end
  end

  assign lfsr_o  = lfsr;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign value_o = value_q;
  assign fb_o    = fb_q;

endmodule

// File: tb/tb_rng_range.sv
// Randomised and directed bench for rng_range (4-bit LFSR).
// Outputs are compared every cycle with a transaction-level model.
module tb_rng_range;

  localparam int W  = 4;
  localparam int OW = 4;
  localparam int MT = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sld;
  logic [W-1:0]  seed;
  logic          req;
  logic [OW-1:0] mx;
  logic [W-1:0]  lfsr;
  logic          busy;
  logic          valid;
  logic [OW-1:0] value;
  logic          fb;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_lfsr, m_busy, m_valid, m_value, m_fb, m_max, m_tries;

  always #10 clk = ~clk;

  rng_range #(
    .WIDTH     (W),
    .OUT_W     (OW),
    .SEED      (4'd1),
    .MAX_TRIES (MT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .seed_load_i (sld),
    .seed_i      (seed),
    .req_i       (req),
    .max_i       (mx),
    .lfsr_o      (lfsr),
    .busy_o      (busy),
    .valid_o     (valid),
    .value_o     (value),
    .fb_o        (fb)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // x^4 + x^3 + 1: feedback is parity of bits 3 and 2.
  function automatic int nxt(input int l);
    int f;
    f = ((l >> 3) ^ (l >> 2)) & 1;
    return ((l * 2) + f) % 16;
  endfunction

  task automatic model_edge();
    int nl, cand, was_busy;
    if (rst) begin
      m_lfsr = 1; m_busy = 0; m_valid = 0;
      m_value = 0; m_fb = 0; m_tries = 0; m_max = 0;
      return;
    end
    nl = m_lfsr;
    was_busy = m_busy;
    m_valid = 0;
    if (sld) begin
      nl = (seed == 0) ? 1 : int'(seed);
    end else if (was_busy != 0) begin
      cand = m_lfsr % 16;
      nl = nxt(m_lfsr);
      if (cand <= m_max) begin
        m_value = cand; m_fb = 0; m_valid = 1; m_busy = 0;
      end else if (m_tries == MT - 1) begin
        m_value = 0; m_fb = 1; m_valid = 1; m_busy = 0;
      end else begin
        m_tries++;
      end
    end else if (en && !req) begin
      nl = nxt(m_lfsr);
    end
    if (was_busy == 0 && req) begin
      m_busy = 1; m_max = int'(mx); m_tries = 0;
    end
    m_lfsr = nl;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("lfsr", int'(lfsr), m_lfsr);
    chk("busy", int'(busy), m_busy);
    chk("valid", int'(valid), m_valid);
    chk("value", int'(value), m_value);
    chk("fb", int'(fb), m_fb);
  endtask

  task automatic idle_in();
    rst = 0; en = 0; sld = 0; seed = '0; req = 0; mx = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!valid && k < budget) begin
      tick();
      k++;
    end
    chk("valid_timeout", int'(valid), 1);
  endtask

  initial begin
    int exp_seq[15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
    int last_v, gaps;

    idle_in();
    rst = 1;
    tick();
    tick();
    chk("rst_lfsr", int'(lfsr), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    rst = 0;

    for (int i = 0; i < 15; i++) begin
      en = 1;
      tick();
      en = 0;
      chk("seq", int'(lfsr), exp_seq[i]);
      chk("seq_nz", int'(lfsr != 0), 1);
      tick();
    end

    do_reset();
    req = 1; mx = 5;
    tick();
    req = 0;
    chk("t2_busy", int'(busy), 1);
    tick();
    chk("t2_valid", int'(valid), 1);
    chk("t2_value", int'(value), 1);
    chk("t2_fb", int'(fb), 0);
    chk("t2_lfsr", int'(lfsr), 2);
    tick();
    chk("t2_pulse", int'(valid), 0);

    do_reset();
    sld = 1; seed = 8;
    tick();
    sld = 0;
    req = 1; mx = 3;
    tick();
    req = 0;
    tick();
    chk("t3_rej", int'(valid), 0);
    tick();
    chk("t3_valid", int'(valid), 1);
    chk("t3_value", int'(value), 1);

    do_reset();
    req = 1; mx = 0;
    tick();
    req = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("t4_early", int'(valid), 0);
    tick();
    chk("t4_valid", int'(valid), 1);
    chk("t4_fb", int'(fb), 1);
    chk("t4_value", int'(value), 0);
    chk("t4_lfsr", int'(lfsr), 5);

    do_reset();
    req = 1; mx = 0;
    tick();
    req = 0;
    tick();
    tick();
    sld = 1; seed = 0;
    tick();
    sld = 0;
    chk("t5_zero_seed", int'(lfsr), 1);
    chk("t5_busy", int'(busy), 1);
    en = 1;
    tick();
    en = 0;
    chk("t5_en_busy", int'(lfsr), 2);
    wait_valid(20);
    chk("t5_fb", int'(fb), 1);
    chk("t5_lfsr", int'(lfsr), 13);

    do_reset();
    req = 1; mx = 0;
    tick();
    req = 0;
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_lfsr", int'(lfsr), 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t6_novalid", int'(valid), 0);
    end

    do_reset();
    req = 1; mx = 4'hF;
    last_v = -1; gaps = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) begin
        if (last_v >= 0) begin
          chk("b2b_gap", cyc - last_v, 2);
          gaps++;
        end
        last_v = cyc;
      end
    end
    chk("b2b_count", int'(gaps >= 5), 1);
    req = 0;

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom % 200) == 0;
      sld  = ($urandom % 30) == 0;
      seed = W'($urandom % 16);
      en   = ($urandom % 2) == 1;
      req  = ($urandom % 3) == 0;
      mx   = OW'($urandom % 16);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
